// File: rtl/rgmii_inband_speed_ctrl.sv
// RGMII in-band status decoder: debounces link/speed/duplex from IFG samples and
// sequences a PHY/MAC reset on speed changes. Optional forced mode: RGMII_SPEED_FORCE_EN.
module rgmii_inband_speed_ctrl #(
  parameter int unsigned STABLE_COUNT  = 8,
  parameter int unsigned RESYNC_CYCLES = 16,
  parameter logic [1:0]  DEFAULT_SPEED = 2'b10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
`ifdef RGMII_SPEED_FORCE_EN
  input  logic       force_en,
  input  logic [1:0] force_speed,
`endif
  output logic [1:0] speed,
  output logic       link_up,
  output logic       full_duplex,
  output logic       link_change,
  output logic       phy_rst_req,
  output logic [1:0] state_dbg
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned STS_W = 4;
  localparam logic [CNT_W-1:0] STABLE_THR  = CNT_W'(STABLE_COUNT);
  localparam logic [CNT_W-1:0] RESYNC_LAST = CNT_W'(RESYNC_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_DOWN   = 2'd0,
    ST_QUAL   = 2'd1,
    ST_RESYNC = 2'd2,
    ST_UP     = 2'd3
  } state_t;

  // Status words are packed as {link, spd[1:0], dup}
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [STS_W-1:0] r_cand;
  logic [STS_W-1:0] r_smp;
  logic             r_smp_vld;
`ifdef RGMII_SPEED_FORCE_EN
  logic             r_force_d;
`endif

  logic             w_valid;
  logic [STS_W-1:0] w_status;
  logic [STS_W-1:0] w_committed;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_eval;
  logic             w_commit;

  assign w_valid     = !gmii_rx_dv && !gmii_rx_er &&
                       (gmii_rxd[7:4] == gmii_rxd[3:0]) && (gmii_rxd[2:1] != 2'b11);
  assign w_status    = {gmii_rxd[0], gmii_rxd[2:1], gmii_rxd[3]};
  assign w_committed = {link_up, speed, full_duplex};
  assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : CNT_W'(r_cnt + 1'b1);
  assign w_next_cnt  = ((r_state == ST_QUAL) && (r_smp == r_cand)) ? w_cnt_inc : CNT_W'(1);
  assign w_commit    = (w_next_cnt >= STABLE_THR);
  assign state_dbg   = r_state;

  // Which registered samples are allowed to (re)start or advance qualification
  always_comb begin
    w_eval = 1'b0;
    case (r_state)
      ST_DOWN: w_eval = r_smp_vld && r_smp[3];
      ST_QUAL: w_eval = r_smp_vld;
      ST_UP:   w_eval = r_smp_vld && (r_smp != w_committed);
      default: w_eval = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_smp_vld <= 1'b0;
      r_smp     <= '0;
    end else begin
      r_smp_vld <= w_valid;
      r_smp     <= w_status;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RESYNC;
      r_cnt       <= '0;
      r_cand      <= '0;
      speed       <= DEFAULT_SPEED;
      link_up     <= 1'b0;
      full_duplex <= 1'b0;
      link_change <= 1'b0;
      phy_rst_req <= 1'b1;
`ifdef RGMII_SPEED_FORCE_EN
      r_force_d   <= 1'b0;
`endif
    end else begin
      link_change <= 1'b0;
`ifdef RGMII_SPEED_FORCE_EN
      r_force_d   <= force_en;
      if (r_force_d && !force_en) begin
        r_state     <= ST_DOWN;
        r_cnt       <= '0;
        r_cand      <= '0;
        link_up     <= 1'b0;
        phy_rst_req <= 1'b0;
        link_change <= link_up;
      end else
`endif
      if (r_state == ST_RESYNC) begin
        // A linked candidate here means the resync followed a speed commit
        if (r_cnt >= RESYNC_LAST) begin
          r_cnt       <= '0;
          phy_rst_req <= 1'b0;
          if (r_cand[3]) begin
            r_state     <= ST_UP;
            link_up     <= 1'b1;
            full_duplex <= r_cand[0];
            link_change <= 1'b1;
          end else begin
            r_state <= ST_DOWN;
          end
        end else begin
          r_cnt <= CNT_W'(r_cnt + 1'b1);
        end
      end
`ifdef RGMII_SPEED_FORCE_EN
      else if (force_en) begin
        if (speed != force_speed) begin
          speed       <= force_speed;
          r_cand      <= {1'b1, force_speed, 1'b1};
          r_state     <= ST_RESYNC;
          r_cnt       <= '0;
          phy_rst_req <= 1'b1;
        end else if ((r_state != ST_UP) || !link_up || !full_duplex) begin
          r_state     <= ST_UP;
          r_cand      <= {1'b1, force_speed, 1'b1};
          link_change <= !link_up || !full_duplex;
          link_up     <= 1'b1;
          full_duplex <= 1'b1;
        end
      end
`endif
      else if (w_eval) begin
        r_cand <= r_smp;
        r_cnt  <= w_next_cnt;
        if (!w_commit) begin
          r_state <= ST_QUAL;
        end else if (!r_smp[3]) begin
          r_state     <= ST_DOWN;
          link_change <= link_up;
          link_up     <= 1'b0;
        end else if (r_smp[2:1] != speed) begin
          speed       <= r_smp[2:1];
          r_state     <= ST_RESYNC;
          r_cnt       <= '0;
          phy_rst_req <= 1'b1;
        end else begin
          r_state     <= ST_UP;
          link_change <= !link_up || (full_duplex != r_smp[0]);
          link_up     <= 1'b1;
          full_duplex <= r_smp[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_rgmii_inband_speed_ctrl.sv
// Bench for rgmii_inband_speed_ctrl: directed vector table plus random IFG traffic
// checked every cycle against a rule-level reference model.
module tb_rgmii_inband_speed_ctrl;

  localparam int unsigned STABLE = 4;
  localparam int unsigned RESYNC = 8;

  logic       clk;
  logic       rst_n;
  logic [7:0] rxd;
  logic       dv;
  logic       er;
  logic [1:0] speed;
  logic       link_up;
  logic       full_duplex;
  logic       link_change;
  logic       phy_rst_req;
  logic [1:0] state_dbg;

  rgmii_inband_speed_ctrl #(
    .STABLE_COUNT (STABLE),
    .RESYNC_CYCLES(RESYNC),
    .DEFAULT_SPEED(2'b10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gmii_rxd   (rxd),
    .gmii_rx_dv (dv),
    .gmii_rx_er (er),
    .speed      (speed),
    .link_up    (link_up),
    .full_duplex(full_duplex),
    .link_change(link_change),
    .phy_rst_req(phy_rst_req),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: committed status, qualification run, resync timer
  logic       m_link, m_dup, m_chg, m_rst, m_go_up;
  logic [1:0] m_spd;
  logic [3:0] m_cand;
  int         m_run, m_left;
  logic       p_vld;
  logic [3:0] p_s;

  typedef struct {
    logic [7:0] rxd;
    logic       dv;
    int         reps;
    logic [7:0] exp;   // {speed, link_up, full_duplex, link_change, phy_rst_req, state}
  } vec_t;

  function automatic logic [7:0] dut_vec();
    return {speed, link_up, full_duplex, link_change, phy_rst_req, state_dbg};
  endfunction

  function automatic logic [7:0] model_vec();
    logic [1:0] st;
    if (m_left > 0)     st = 2'd2;
    else if (m_run > 0) st = 2'd1;
    else if (m_link)    st = 2'd3;
    else                st = 2'd0;
    return {m_spd, m_link, m_dup, m_chg, m_rst, st};
  endfunction

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_link = 1'b0; m_spd = 2'b10; m_dup = 1'b0; m_chg = 1'b0; m_rst = 1'b1;
    m_left = RESYNC; m_go_up = 1'b0; m_run = 0; m_cand = '0;
    p_vld = 1'b0; p_s = '0;
  endtask

  // One clock edge of the rules: act on last cycle's sample, then capture this one
  task automatic model_step();
    logic [3:0] s;
    logic       take;
    m_chg = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_rst = 1'b0;
        m_run = 0;
        if (m_go_up) begin m_link = 1'b1; m_dup = m_cand[0]; m_chg = 1'b1; end
        m_go_up = 1'b0;
      end
    end else if (p_vld) begin
      s = p_s;
      if (m_run > 0)   take = 1'b1;
      else if (m_link) take = (s != {1'b1, m_spd, m_dup});
      else             take = s[3];
      if (take) begin
        if (m_run > 0 && s == m_cand) m_run++;
        else begin m_cand = s; m_run = 1; end
        if (m_run >= STABLE) begin
          m_run = 0;
          if (!s[3]) begin
            m_chg = m_link; m_link = 1'b0;
          end else if (s[2:1] != m_spd) begin
            m_spd = s[2:1]; m_left = RESYNC; m_rst = 1'b1; m_go_up = 1'b1;
          end else begin
            m_chg = !m_link || (m_dup != s[0]); m_link = 1'b1; m_dup = s[0];
          end
        end
      end
    end
    p_vld = !dv && !er && (rxd[7:4] == rxd[3:0]) && (rxd[2:1] != 2'b11);
    p_s   = {rxd[0], rxd[2:1], rxd[3]};
  endtask

  task automatic tick_neg();
    @(negedge clk);
    check8("model", dut_vec(), model_vec());
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic e);
    rxd = d; dv = v; er = e;
    @(posedge clk);
    if (rst_n) model_step();
  endtask

  vec_t       vecs[$];
  int         hi;
  logic       done;
  logic [7:0] pool[10];

  initial begin
    vecs = '{
      '{8'hDD, 1'b0, 4, 8'hBB}, '{8'hBB, 1'b0, 4, 8'h76}, '{8'h55, 1'b1, 6, 8'h7B},
      '{8'h99, 1'b0, 3, 8'h71}, '{8'h55, 1'b1, 1, 8'h71}, '{8'h99, 1'b0, 1, 8'h36},
      '{8'h55, 1'b1, 6, 8'h3B}, '{8'h99, 1'b0, 2, 8'h33}, '{8'hDD, 1'b0, 1, 8'h31},
      '{8'h5D, 1'b0, 1, 8'h31}, '{8'hDD, 1'b0, 2, 8'h31}, '{8'h77, 1'b0, 1, 8'h31},
      '{8'hDD, 1'b0, 1, 8'hB6}, '{8'h55, 1'b1, 6, 8'hBB}, '{8'hBB, 1'b0, 2, 8'hB1},
      '{8'hDD, 1'b0, 1, 8'hB1}, '{8'hDD, 1'b0, 3, 8'hB3}, '{8'h00, 1'b0, 4, 8'h98},
      '{8'h00, 1'b0, 4, 8'h90}, '{8'h55, 1'b0, 4, 8'hAB}, '{8'h33, 1'b0, 4, 8'h66}
    };
    pool = '{8'h00, 8'hDD, 8'hBB, 8'h99, 8'h55, 8'h33, 8'h11, 8'h77, 8'h5D, 8'h00};

    rst_n = 1'b0; rxd = 8'h00; dv = 1'b0; er = 1'b0;
    model_reset();
    repeat (3) begin tick_neg(); drive(8'h00, 1'b0, 1'b0); end

    // Reset release: reset request lasts RESYNC cycles, then DOWN
    tick_neg();
    check8("reset_vals", dut_vec(), 8'h86);
    rst_n = 1'b1;
    drive(8'h00, 1'b0, 1'b0);
    hi = 1; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick_neg();
      if (!phy_rst_req) done = 1'b1;
      else begin hi++; drive(8'h00, 1'b0, 1'b0); end
    end
    check8("resync_len", 8'(hi), 8'(RESYNC));
    check8("post_reset", dut_vec(), 8'h80);
    drive(8'h00, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        tick_neg(); drive(vecs[i].rxd, vecs[i].dv, 1'b0);
      end
      tick_neg(); drive(8'h55, 1'b1, 1'b0);
      tick_neg();
      check8($sformatf("vec%0d", i), dut_vec(), vecs[i].exp);
      drive(8'h55, 1'b1, 1'b0);
    end

    // Asynchronous reset in the middle of a speed-change resync
    repeat (3) begin tick_neg(); drive(8'h55, 1'b1, 1'b0); end
    tick_neg();
    rst_n = 1'b0;
    model_reset();
    #1;
    check8("async_reset", dut_vec(), 8'h86);
    drive(8'h00, 1'b0, 1'b0);
    repeat (2) begin tick_neg(); drive(8'h00, 1'b0, 1'b0); end
    tick_neg();
    rst_n = 1'b1;
    drive(8'h00, 1'b0, 1'b0);

    for (int k = 0; k < 500; k++) begin
      logic [7:0] v;
      int         len;
      logic       fv, fe;
      v   = pool[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) v = 8'($urandom);
      len = $urandom_range(1, 6);
      for (int r = 0; r < len; r++) begin
        fv = ($urandom_range(0, 7) == 0);
        fe = ($urandom_range(0, 15) == 0);
        tick_neg(); drive(v, fv, fe);
      end
      if (k == 250) begin
        tick_neg();
        rst_n = 1'b0;
        model_reset();
        #1;
        check8("async_reset_rand", dut_vec(), 8'h86);
        drive(8'h00, 1'b0, 1'b0);
        tick_neg();
        rst_n = 1'b1;
        drive(8'h00, 1'b0, 1'b0);
      end
    end
    tick_neg();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
